// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared FSM state type, seed width and parameter defaults for the
// AES/PRNG sequencer.
package aes_seq_pkg;

   typedef enum logic [1:0] {SEED, SEED_WAIT, IDLE, RUN} seq_state_t;

   localparam int SEED_W            = 80;
   localparam int DEF_RESEED_PERIOD = 1024;
   localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/aes_seq_reseed_ctr.sv
// aes_seq_reseed_ctr: encryption counter, pending-reseed flag and reseed-due decision.
// AUTO_RESEED_EN adds a periodic reseed after RESEED_PERIOD encryptions.
module aes_seq_reseed_ctr
   import aes_seq_pkg::*;
#(
   parameter int RESEED_PERIOD = DEF_RESEED_PERIOD,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             req,
   output logic [CNT_W-1:0] count,
   output logic             pending,
   output logic             due
);

   logic [CNT_W-1:0] count_q, count_d;
   logic             pending_q, pending_d;
   logic             auto_hit;

   if (RESEED_PERIOD < 1 || longint'(RESEED_PERIOD) >= (longint'(1) << CNT_W)) begin : g_bad_period
      $error("RESEED_PERIOD must lie in 1 .. 2**CNT_W-1");
   end

`ifdef AUTO_RESEED_EN
   assign auto_hit = count_q == CNT_W'(RESEED_PERIOD - 1);
`else
   assign auto_hit = 1'b0;
`endif

   // A clear wins over a same-cycle request: that reseed is already starting.
   always_comb begin
      count_d   = clr ? '0 : count_q + CNT_W'(inc);
      pending_d = !clr && (pending_q || req);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   assign count   = count_q;
   assign pending = pending_q;
   assign due     = pending_q || req || auto_hit;

endmodule

// File: rtl/aes_prng_sequencer.sv
// aes_prng_sequencer: seeds the PRNG, gates encryption requests on core/PRNG readiness
// and schedules reseeds between encryptions (periodic reseed under AUTO_RESEED_EN).
module aes_prng_sequencer
   import aes_seq_pkg::*;
#(
   parameter int RESEED_PERIOD = DEF_RESEED_PERIOD,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   output logic              done,
   input  logic [SEED_W-1:0] seed_in,
   input  logic              reseed_req,
   output logic              core_valid_in,
   input  logic              core_ready,
   input  logic              core_cipher_valid,
   output logic [SEED_W-1:0] prng_seed,
   output logic              prng_start_reseed,
   output logic              prng_out_ready,
   input  logic              prng_out_valid,
   input  logic              prng_busy,
   output logic [CNT_W-1:0]  enc_count,
   output logic              rnd_err
);

   seq_state_t        state_q, state_d;
   logic              done_q, done_d;
   logic              start_q, start_d;
   logic              err_q, err_d;
   logic [SEED_W-1:0] seed_q, seed_d;
   logic              pending, due, finish;

   assign finish         = state_q == RUN && core_cipher_valid;
   assign req_ready      = state_q == IDLE && core_ready && prng_out_valid && !pending;
   assign core_valid_in  = req_valid && req_ready;
   assign prng_out_ready = state_q == RUN;

   aes_seq_reseed_ctr #(
      .RESEED_PERIOD (RESEED_PERIOD),
      .CNT_W         (CNT_W)
   ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == SEED),
      .inc     (finish),
      .req     (reseed_req),
      .count   (enc_count),
      .pending (pending),
      .due     (due)
   );

   // The first SEED_WAIT cycle carries the reseed pulse, so a stale valid from the
   // previous seed must not end the wait there.
   always_comb begin
      seed_d  = state_q == SEED ? seed_in : seed_q;
      start_d = state_q == SEED;
      done_d  = finish;
      err_d   = err_q || (prng_out_ready && !prng_out_valid);
      state_d = state_q;
      case (state_q)
         SEED:      state_d = SEED_WAIT;
         SEED_WAIT: if (!start_q && !prng_busy && prng_out_valid) state_d = pending ? SEED : IDLE;
         IDLE:      state_d = pending ? SEED : core_valid_in ? RUN : IDLE;
         RUN:       if (core_cipher_valid) state_d = due ? SEED : IDLE;
         default:   state_d = SEED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
         done_q  <= 1'b0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         seed_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         start_q <= start_d;
         err_q   <= err_d;
         seed_q  <= seed_d;
      end
   end

   assign done              = done_q;
   assign prng_start_reseed = start_q;
   assign prng_seed         = seed_q;
   assign rnd_err           = err_q;

endmodule
